// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one data memory between CPU and debug ports
module mem_port_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [1:0]            cpu_mask,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic                  cpu_stall,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [1:0]            dbg_mask,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_ack,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [1:0]            mem_mask,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic          winner;
    logic          rr_last;
    logic          pick_dbg;
    logic [CW-1:0] cnt;

    // dbg wins when it is the sole requester, or on a tie when the CPU was served last
    assign pick_dbg  = dbg_req & (~cpu_req | ~rr_last);
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign busy      = state != IDLE;

    // arbitration FSM: grant, hold command until ready or timeout, then pulse the ack
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            winner    <= 1'b0;
            rr_last   <= 1'b1;
            cnt       <= '0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_mask  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req | dbg_req) begin
                        winner    <= pick_dbg;
                        mem_we    <= pick_dbg ? dbg_we    : cpu_we;
                        mem_mask  <= pick_dbg ? dbg_mask  : cpu_mask;
                        mem_addr  <= pick_dbg ? dbg_addr  : cpu_addr;
                        mem_wdata <= pick_dbg ? dbg_wdata : cpu_wdata;
                        mem_req   <= 1'b1;
                        cnt       <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready || cnt == LAST) begin
                        rsp_rdata <= (mem_ready && !mem_we) ? mem_rdata : '0;
                        rsp_err   <= ~mem_ready;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        cpu_ack   <= ~winner;
                        dbg_ack   <= winner;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    cpu_ack <= 1'b0;
                    dbg_ack <= 1'b0;
                    rr_last <= winner;
                    cnt     <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus scoreboard of expected completions
module tb_mem_port_arbiter;
    logic        clk = 0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [1:0]  cpu_mask;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        dbg_req, dbg_we, dbg_ack;
    logic [1:0]  dbg_mask;
    logic [31:0] dbg_addr, dbg_wdata;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req, mem_we, mem_ready, busy;
    logic [1:0]  mem_mask;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    int          mem_wait = 0;
    logic [31:0] mem_resp = 0;
    bit          mem_en = 1;

    typedef struct {
        bit          port;
        bit          we;
        logic [1:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wcyc;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];

    mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_mask(cpu_mask), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_mask(dbg_mask), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_mask(mem_mask), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // memory model: asserts mem_ready after mem_wait cycles of mem_req
    initial begin
        int wcnt;
        wcnt = 0;
        mem_ready = 0;
        mem_rdata = 0;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                if (mem_req && wcnt == mem_wait) begin
                    mem_ready = 1;
                    mem_rdata = mem_resp;
                    wcnt = 0;
                end else if (mem_req) begin
                    mem_ready = 0;
                    wcnt++;
                end else begin
                    mem_ready = 0;
                    wcnt = 0;
                end
            end
        end
    end

    // scoreboard: every ack must match the oldest expected completion
    always @(negedge clk) begin
        if (cpu_ack || dbg_ack) begin
            exp_t e;
            chk("ack_overlap", 32'(cpu_ack & dbg_ack), 32'(0));
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'(1), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("ack_port", 32'(dbg_ack), 32'(e.port));
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    task automatic do_txn(input vec_t v);
        int  k;
        int  mreq;
        bit  got;
        @(posedge clk); #1;
        mem_wait = v.wcyc;
        mem_resp = v.rdata;
        sb.push_back('{v.port, v.exp_rdata, v.exp_err});
        if (v.port) begin
            dbg_req = 1; dbg_we = v.we; dbg_mask = v.mask; dbg_addr = v.addr; dbg_wdata = v.wdata;
        end else begin
            cpu_req = 1; cpu_we = v.we; cpu_mask = v.mask; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end
        k = 0;
        mreq = 0;
        got = 0;
        while (!got && k < 300) begin
            @(negedge clk);
            if (mem_req) begin
                mreq++;
                chk("mem_addr", mem_addr, v.addr);
                chk("mem_we", 32'(mem_we), 32'(v.we));
                chk("mem_mask", 32'(mem_mask), 32'(v.mask));
                chk("mem_wdata", mem_wdata, v.wdata);
            end
            chk("cpu_stall", 32'(cpu_stall), 32'(!v.port && k != v.exp_lat));
            if (v.port ? dbg_ack : cpu_ack) got = 1;
            else k++;
        end
        chk("ack_latency", 32'(k), 32'(v.exp_lat));
        chk("mem_req_cycles", 32'(mreq), 32'(v.exp_lat - 1));
        @(posedge clk); #1;
        cpu_req = 0;
        dbg_req = 0;
    endtask

    initial begin
        int n;
        vecs[0] = '{0, 0, 2'b10, 32'h10, 32'h0,        32'hDEADBEEF, 0,  32'hDEADBEEF, 0, 2};
        vecs[1] = '{1, 1, 2'b10, 32'h40, 32'h12345678, 32'h77777777, 3,  32'h0,        0, 5};
        vecs[2] = '{0, 0, 2'b00, 32'h13, 32'h0,        32'h000000A5, 1,  32'h000000A5, 0, 3};
        vecs[3] = '{1, 0, 2'b01, 32'h22, 32'h0,        32'h0000CAFE, 0,  32'h0000CAFE, 0, 2};
        vecs[4] = '{0, 0, 2'b10, 32'h30, 32'h0,        32'h11111111, 99, 32'h0,        1, 9};
        vecs[5] = '{0, 1, 2'b10, 32'h80, 32'hA0A0A0A0, 32'h22222222, 7,  32'h0,        0, 9};
        vecs[6] = '{1, 0, 2'b10, 32'h44, 32'h0,        32'h55AA55AA, 2,  32'h55AA55AA, 0, 4};

        rst = 1;
        cpu_req = 0; cpu_we = 0; cpu_mask = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_mask = 0; dbg_addr = 0; dbg_wdata = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_mem_req", 32'(mem_req), 32'(0));
        chk("rst_mem_we", 32'(mem_we), 32'(0));
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'(0));
        chk("rst_acks", 32'({cpu_ack, dbg_ack}), 32'(0));

        for (int i = 0; i < 7; i++) do_txn(vecs[i]);

        mem_en = 0;
        @(posedge clk); #1;
        mem_ready = 1;
        mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("idle_ready_busy", 32'(busy), 32'(0));
        @(posedge clk); #1;
        mem_ready = 0;
        @(negedge clk);
        chk("idle_ready_busy2", 32'(busy), 32'(0));
        chk("idle_ready_rdata", rsp_rdata, vecs[6].exp_rdata);
        mem_en = 1;

        @(posedge clk); #1;
        mem_wait = 0;
        mem_resp = 32'h0BADF00D;
        for (int i = 0; i < 4; i++) sb.push_back('{bit'(i % 2), 32'h0BADF00D, 1'b0});
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h200;
        n = 0;
        for (int c = 0; c < 100 && n < 4; c++) begin
            @(negedge clk);
            if (cpu_ack || dbg_ack) n++;
        end
        chk("rr_ack_count", 32'(n), 32'(4));
        @(posedge clk); #1;
        cpu_req = 0;
        dbg_req = 0;

        @(posedge clk); #1;
        mem_wait = 99;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_mem_req_before", 32'(mem_req), 32'(1));
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        cpu_req = 0;
        chk("abort_mem_req", 32'(mem_req), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_ack", 32'(cpu_ack), 32'(0));
        chk("abort_rdata", rsp_rdata, 32'h0);
        repeat (3) @(negedge clk);
        chk("abort_idle", 32'(busy), 32'(0));
        do_txn(vecs[0]);

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
